photon_gate_ctrl: RTL and testbench
===================================

Name: photon_gate_ctrl

Overview:
Single-channel gated photon-counting controller. It sequences the edge detector's enable, opens a measurement window of programmable length, and counts detected rising edges with dead-time suppression and saturation. The result is delivered over a valid/ready handshake to the display/readout logic. It sits between the synchronised detector front end and the TFT readout path.

Parameters:
CNT_W, 16, width of photon count result
GATE_W, 24, width of gate length (window in clk cycles)
DEAD_CYCLES, 4, cycles after a counted edge during which further edges are ignored (≥1)
ARM_CYCLES, 2, settle cycles after enabling detector before counting (covers its 2-stage sync refill)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request one measurement; honoured only in IDLE
abort  input  1  cancel current measurement; no result produced
gate_len  input  GATE_W  window length in cycles, latched on accepted start
rise_in  input  1  rising_edge strobe from edge detector (already clk-synchronous)
det_en  output  1  enable to edge detector
busy  output  1  high in any state other than IDLE
cnt_out  output  CNT_W  photon count; stable while cnt_valid high
cnt_valid  output  1  result available
cnt_ready  input  1  consumer accepts result
overflow  output  1  count saturated in this measurement; qualified by cnt_valid

Behaviour:
- Reset (async): state=IDLE; det_en=0, busy=0, cnt_valid=0, cnt_out=0, overflow=0, internal counters 0.
- States: IDLE, ARM, GATE, HOLD; all outputs registered.
- IDLE: start=1 at edge T → latch gate_len, clear count/overflow/dead counter, go to ARM; det_en=1 and busy=1 from T+1.
- ARM: lasts exactly ARM_CYCLES cycles; rise_in ignored (suppresses spurious edge when detector enable rises with sig_in already high). Then GATE if latched gate_len≠0, else directly HOLD with count 0.
- GATE: lasts exactly latched gate_len cycles (first GATE cycle = T+1+ARM_CYCLES). Each cycle: if rise_in=1 and dead counter=0 → count+1, dead counter loaded with DEAD_CYCLES; else if dead counter>0 → decrement. rise_in while dead counter>0 is dropped. Edge on final GATE cycle is counted.
- Saturation: increment at count=all-ones keeps all-ones and sets overflow; overflow sticky until next accepted start.
- GATE end → HOLD: det_en=0, cnt_valid=1, cnt_out=final count, same cycle.
- HOLD: cnt_out/overflow held; transfer when cnt_valid&&cnt_ready at edge → next cycle IDLE, cnt_valid=0, busy=0. cnt_ready outside HOLD ignored.
- start outside IDLE ignored (not queued); start in the cycle that returns to IDLE also ignored — next start sampled in IDLE.
- abort in ARM or GATE → IDLE next cycle, det_en=0, no cnt_valid. abort in HOLD ignored (result must be consumed). abort has priority over GATE completion in the same cycle. abort in IDLE has priority over start.
- gate_len changes after latch have no effect on current measurement.
- Dead counter does not carry between measurements.

Test Plan:
- Basic: gate_len=20, ARM_CYCLES=2, DEAD_CYCLES=4, start at cycle 0, rise_in pulses at cycles 5,12,18 → det_en high cycles 1..22, cnt_valid rises cycle 23 with cnt_out=3, overflow=0.
- Dead time: gate_len=20, rise_in at cycles 5,7,9,10 → cnt_out=2 (5 counted, 7/9 dropped, 10 counted: dead counter expired).
- ARM masking: rise_in high at cycles 1 and 2 only, gate_len=10 → cnt_out=0.
- Saturation: CNT_W=4, DEAD_CYCLES=1, gate_len=40, rise_in every other cycle in GATE (20 edges) → cnt_out=15, overflow=1; next measurement with no edges → cnt_out=0, overflow=0.
- Handshake/backpressure: cnt_ready low 10 cycles after cnt_valid → cnt_out stable, start pulses ignored, busy=1; cnt_ready=1 → idle next cycle; start then accepted.
- Abort/reset/zero: abort at cycle 8 of GATE → IDLE, det_en=0, no cnt_valid; gate_len=0 → cnt_valid at cycle 3 with cnt_out=0; rst_n low mid-GATE → all outputs 0 immediately.

Source files
------------

// File: rtl/photon_gate_ctrl.sv
// photon_gate_ctrl: gated photon counter with arm settle, dead-time suppression,
// saturating count and a valid/ready result handshake.
module photon_gate_ctrl #(
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 24,
   parameter int DEAD_CYCLES = 4,
   parameter int ARM_CYCLES  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              rise_in,
   output logic              det_en,
   output logic              busy,
   output logic [CNT_W-1:0]  cnt_out,
   output logic              cnt_valid,
   input  logic              cnt_ready,
   output logic              overflow
);
   localparam int AW = ARM_CYCLES > 1 ? $clog2(ARM_CYCLES) : 1;
   localparam int DW = $clog2(DEAD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} state_t;

   state_t            state, nxt;
   logic [GATE_W-1:0] gate_rem;
   logic [AW-1:0]     arm_cnt;
   logic [DW-1:0]     dead;
   logic              det_en_d, busy_d, valid_d;
   logic              accept, arm_done, gate_last, hit;

   assign accept    = state == IDLE && start && !abort;
   assign arm_done  = arm_cnt == '0;
   assign gate_last = gate_rem == GATE_W'(1);
   assign hit       = state == GATE && rise_in && dead == '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         det_en    <= 1'b0;
         busy      <= 1'b0;
         cnt_valid <= 1'b0;
      end else begin
         state     <= nxt;
         det_en    <= det_en_d;
         busy      <= busy_d;
         cnt_valid <= valid_d;
      end

   // abort outranks both start (in IDLE) and gate completion
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = accept ? ARM : IDLE;
         ARM:     nxt = abort ? IDLE : !arm_done ? ARM : gate_rem == '0 ? HOLD : GATE;
         GATE:    nxt = abort ? IDLE : gate_last ? HOLD : GATE;
         HOLD:    nxt = cnt_ready ? IDLE : HOLD;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      det_en_d = nxt == ARM || nxt == GATE;
      busy_d   = nxt != IDLE;
      valid_d  = nxt == HOLD;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gate_rem <= '0;
         arm_cnt  <= '0;
         dead     <= '0;
         cnt_out  <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         gate_rem <= gate_len;
         arm_cnt  <= AW'(ARM_CYCLES - 1);
         dead     <= '0;
         cnt_out  <= '0;
         overflow <= 1'b0;
      end else begin
         if (state == ARM && !arm_done)
            arm_cnt <= arm_cnt - AW'(1);
         if (state == GATE) begin
            gate_rem <= gate_rem - GATE_W'(1);
            dead     <= hit ? DW'(DEAD_CYCLES) : dead != '0 ? dead - DW'(1) : dead;
            if (hit) begin
               if (&cnt_out)
                  overflow <= 1'b1;
               else
                  cnt_out <= cnt_out + CNT_W'(1);
            end
         end
      end

   a_valid_no_det: assert property (@(posedge clk) disable iff (!rst_n) cnt_valid |-> !det_en && busy);
endmodule

// File: tb/tb_photon_gate_ctrl.sv
// tb_photon_gate_ctrl: randomized and directed checks of photon_gate_ctrl against a
// measurement-level model (window by cycle arithmetic, dead time by edge spacing).
module tb_photon_gate_ctrl;
   localparam int ARM = 2;

   logic        clk = 0, rst_n = 0, start = 0, abort = 0, rise_in = 0, cnt_ready = 0;
   logic [23:0] gate_len = 0;
   logic        det_en, busy, cnt_valid, overflow;
   logic [15:0] cnt_out;
   logic        det_en_s, busy_s, cnt_valid_s, overflow_s;
   logic [3:0]  cnt_out_s;

   int n_chk = 0, n_fail = 0, cyc = 0;

   photon_gate_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
      .rise_in(rise_in), .det_en(det_en), .busy(busy), .cnt_out(cnt_out),
      .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .overflow(overflow)
   );

   photon_gate_ctrl #(.CNT_W(4), .DEAD_CYCLES(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
      .rise_in(rise_in), .det_en(det_en_s), .busy(busy_s), .cnt_out(cnt_out_s),
      .cnt_valid(cnt_valid_s), .cnt_ready(cnt_ready), .overflow(overflow_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   bit        m_busy = 0, m_hold = 0;
   int        m_t0 = 0, m_len = 0;
   int        edges[$];
   int        e_cnt = 0, e_cnt_s = 0;
   bit        e_ovf_s = 0;

   function automatic int filt(input int dead);
      int n = 0, last = -100000;
      foreach (edges[i])
         if (edges[i] - last > dead) begin
            n++;
            last = edges[i];
         end
      return n;
   endfunction

   // model: one measurement = start cycle t0, window t0+1+ARM .. t0+ARM+len
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_busy = 0;
         m_hold = 0;
      end else begin
         if (!m_busy) begin
            if (start && !abort) begin
               m_busy = 1;
               m_t0   = cyc;
               m_len  = int'(gate_len);
               edges.delete();
            end
         end else if (m_hold) begin
            if (cnt_ready) begin
               m_busy = 0;
               m_hold = 0;
            end
         end else if (abort)
            m_busy = 0;
         else begin
            if (rise_in && cyc >= m_t0 + 1 + ARM) edges.push_back(cyc);
            if (cyc == m_t0 + ARM + m_len) begin
               m_hold  = 1;
               e_cnt   = filt(4);
               e_cnt_s = filt(1) > 15 ? 15 : filt(1);
               e_ovf_s = filt(1) > 15;
            end
         end
         cyc++;
      end

   always @(negedge clk) begin
      check("det_en", det_en, m_busy && !m_hold);
      check("busy", busy, m_busy);
      check("cnt_valid", cnt_valid, m_hold);
      check("det_en_s", det_en_s, m_busy && !m_hold);
      check("cnt_valid_s", cnt_valid_s, m_hold);
      if (m_hold) begin
         check("cnt_out", cnt_out, e_cnt);
         check("overflow", overflow, 0);
         check("cnt_out_s", cnt_out_s, e_cnt_s);
         check("overflow_s", overflow_s, e_ovf_s);
      end
   end

   task automatic run(input int len, input logic [127:0] mask, output int lat);
      lat      = -1;
      gate_len = 24'(len);
      start    = 1;
      rise_in  = mask[0];
      @(negedge clk);
      start    = 0;
      gate_len = 24'($urandom);
      for (int k = 1; k < 200; k++) begin
         rise_in = k < 128 ? mask[k] : 1'b0;
         if (cnt_valid) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      rise_in = 0;
      if (lat < 0) check("valid_timeout", 0, 1);
   endtask

   task automatic consume(input int stall);
      logic [15:0] held;
      held = cnt_out;
      for (int i = 0; i < stall; i++) begin
         start     = i[0];
         cnt_ready = 0;
         check("hold_busy", busy, 1);
         check("hold_cnt", cnt_out, held);
         @(negedge clk);
      end
      start     = 0;
      cnt_ready = 1;
      @(negedge clk);
      cnt_ready = 0;
      check("idle_busy", busy, 0);
      check("idle_valid", cnt_valid, 0);
   endtask

   initial begin
      int          lat;
      bit          seen;
      logic [127:0] m;
      repeat (3) @(negedge clk);
      check("rst_det_en", det_en, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", cnt_valid, 0);
      check("rst_cnt", cnt_out, 0);
      check("rst_ovf", overflow, 0);
      rst_n = 1;
      @(negedge clk);

      m = '0; m[5] = 1; m[12] = 1; m[18] = 1;
      run(20, m, lat);
      check("basic_lat", lat, 23);
      check("basic_cnt", cnt_out, 3);
      check("basic_ovf", overflow, 0);
      consume(10);

      m = '0; m[5] = 1; m[7] = 1; m[9] = 1; m[10] = 1;
      run(20, m, lat);
      check("dead_cnt", cnt_out, 2);
      consume(0);

      m = '0; m[1] = 1; m[2] = 1;
      run(10, m, lat);
      check("arm_lat", lat, 13);
      check("arm_cnt", cnt_out, 0);
      consume(0);

      m = '0;
      for (int i = 3; i <= 41; i += 2) m[i] = 1;
      run(40, m, lat);
      check("sat_lat", lat, 43);
      check("sat_cnt_s", cnt_out_s, 15);
      check("sat_ovf_s", overflow_s, 1);
      check("sat_cnt_dead4", cnt_out, 7);
      consume(0);
      run(5, '0, lat);
      check("post_sat_cnt_s", cnt_out_s, 0);
      check("post_sat_ovf_s", overflow_s, 0);
      consume(0);

      run(0, '0, lat);
      check("zero_lat", lat, 3);
      check("zero_cnt", cnt_out, 0);
      consume(0);

      gate_len = 20;
      start    = 1;
      @(negedge clk);
      start = 0;
      repeat (10) @(negedge clk);
      check("gate_det_en", det_en, 1);
      abort = 1;
      @(negedge clk);
      abort = 0;
      check("abort_det_en", det_en, 0);
      check("abort_busy", busy, 0);
      seen = 0;
      repeat (30) begin
         if (cnt_valid) seen = 1;
         @(negedge clk);
      end
      check("abort_novalid", seen, 0);

      start = 1;
      abort = 1;
      @(negedge clk);
      start = 0;
      abort = 0;
      check("idle_abort_wins", busy, 0);

      gate_len = 20;
      start    = 1;
      @(negedge clk);
      start = 0;
      repeat (6) @(negedge clk);
      check("pre_rst_det_en", det_en, 1);
      #2 rst_n = 0;
      #1;
      check("mid_rst_det_en", det_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", cnt_valid, 0);
      check("mid_rst_cnt", cnt_out, 0);
      check("mid_rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         start     = $urandom_range(0, 3) == 0;
         abort     = $urandom_range(0, 59) == 0;
         rise_in   = $urandom_range(0, 1) == 1;
         cnt_ready = $urandom_range(0, 2) == 0;
         gate_len  = 24'($urandom_range(0, 50));
         @(negedge clk);
      end
      start     = 0;
      abort     = 0;
      rise_in   = 0;
      cnt_ready = 1;
      repeat (60) @(negedge clk);
      check("drain_idle", busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
